// File: rtl/sort_matrix_loader_if.sv
// Stream-in / matrix-out bus between the element source, the loader and the mesh sorter.
// The master drives the element stream; the slave (loader) returns the published matrix and status.
interface sort_matrix_loader_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [N*N*WIDTH-1:0]   matrix_out;
  logic                   matrix_valid;
  logic                   sort_done;
  logic                   busy;
  logic                   frame_err;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  matrix_out,
    input  matrix_valid,
    input  sort_done,
    input  busy,
    input  frame_err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output matrix_out,
    output matrix_valid,
    output sort_done,
    output busy,
    output frame_err
  );
endinterface

// File: rtl/sort_matrix_loader.sv
// Assembles a serial element stream into an N*N matrix, publishes it atomically to the
// mesh sorter and pulses sort_done once the sorter's fixed latency has elapsed.
module sort_matrix_loader #(
  parameter int N            = 8,
  parameter int WIDTH        = 8,
  parameter int SORT_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  sort_matrix_loader_if.slave bus
);

  localparam int ELEMS = N * N;
  localparam int IW    = $clog2(ELEMS);
  localparam int LW    = $clog2(SORT_LATENCY + 1);
  localparam int MW    = ELEMS * WIDTH;

  localparam logic [IW-1:0] IDX_LAST = IW'(ELEMS - 1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(SORT_LATENCY);
  localparam logic [LW-1:0] LAT_ONE  = LW'(1);
  localparam logic [LW-1:0] LAT_ZERO = LW'(0);

  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   cnt_r;
  logic [IW-1:0]   cnt_nxt_s;
  logic [MW-1:0]   fill_r;
  logic [MW-1:0]   fill_nxt_s;
  logic [MW-1:0]   matrix_r;
  logic [LW-1:0]   lat_r;
  logic [LW-1:0]   lat_nxt_s;
  logic            matrix_valid_r;
  logic            sort_done_r;
  logic            busy_r;
  logic            frame_err_r;
  logic            in_ready_r;

  logic            xfer_s;
  logic            last_slot_s;
  logic            complete_s;
  logic            ferr_s;
  logic            store_s;
  logic            lat_free_s;
  logic            expiring_s;
  logic            publish_s;

  // Handshake and framing decode; a framing error is any disagreement between in_last and the slot.
  assign xfer_s      = bus.in_valid && in_ready_r;
  assign last_slot_s = (cnt_r == IDX_LAST);
  assign complete_s  = xfer_s && last_slot_s && bus.in_last;
  assign ferr_s      = xfer_s && (bus.in_last != last_slot_s);
  assign store_s     = xfer_s && !ferr_s;
  assign expiring_s  = (lat_r == LAT_ONE);
  // The sorter is free if idle or if its current matrix retires on this very edge.
  assign lat_free_s  = (lat_r == LAT_ZERO) || expiring_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (complete_s && !lat_free_s) begin
          state_nxt_s = ST_PENDING;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_PENDING: begin
        if (expiring_s) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_PENDING;
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
      end
    endcase
  end

  // FSM outputs: publish decision plus next values of index, fill buffer and latency counter.
  always_comb begin
    publish_s  = 1'b0;
    cnt_nxt_s  = cnt_r;
    fill_nxt_s = fill_r;
    lat_nxt_s  = lat_r;

    case (state_r)
      ST_FILL: begin
        publish_s = complete_s && lat_free_s;
      end
      ST_PENDING: begin
        publish_s = expiring_s;
      end
      default: begin
        publish_s = 1'b0;
      end
    endcase

    if (xfer_s) begin
      if (ferr_s || complete_s) begin
        cnt_nxt_s = IDX_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + IDX_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (store_s) begin
      fill_nxt_s[cnt_r*WIDTH +: WIDTH] = bus.in_data;
    end else begin
      fill_nxt_s = fill_r;
    end

    if (publish_s) begin
      lat_nxt_s = LAT_LOAD;
    end else if (lat_r != LAT_ZERO) begin
      lat_nxt_s = lat_r - LAT_ONE;
    end else begin
      lat_nxt_s = lat_r;
    end
  end

  // Datapath and registered status outputs; matrix_r moves only on publish edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r          <= IDX_ZERO;
      fill_r         <= {MW{1'b0}};
      matrix_r       <= {MW{1'b0}};
      lat_r          <= LAT_ZERO;
      matrix_valid_r <= 1'b0;
      sort_done_r    <= 1'b0;
      busy_r         <= 1'b0;
      frame_err_r    <= 1'b0;
      in_ready_r     <= 1'b1;
    end else begin
      cnt_r       <= cnt_nxt_s;
      fill_r      <= fill_nxt_s;
      lat_r       <= lat_nxt_s;
      busy_r      <= (lat_nxt_s != LAT_ZERO);
      sort_done_r <= expiring_s;
      frame_err_r <= ferr_s;
      in_ready_r  <= (state_nxt_s == ST_FILL);
      if (publish_s) begin
        matrix_r       <= fill_nxt_s;
        matrix_valid_r <= 1'b1;
      end else begin
        matrix_r       <= matrix_r;
        matrix_valid_r <= matrix_valid_r;
      end
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.matrix_out   = matrix_r;
  assign bus.matrix_valid = matrix_valid_r;
  assign bus.sort_done    = sort_done_r;
  assign bus.busy         = busy_r;
  assign bus.frame_err    = frame_err_r;

endmodule

// File: tb/tb_sort_matrix_loader.sv
// Directed bench for sort_matrix_loader: one instance at SORT_LATENCY=2, one at 70 for back-to-back.
module tb_sort_matrix_loader;

  logic clk;
  logic reset;
  logic [7:0] d;
  logic v;
  logic l;
  logic sel;
  int n_assert;
  int n_fail;
  int done_a, done_b, ferr_a;

  sort_matrix_loader_if #(.N(8), .WIDTH(8)) if_a ();
  sort_matrix_loader_if #(.N(8), .WIDTH(8)) if_b ();

  sort_matrix_loader #(.N(8), .WIDTH(8), .SORT_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  sort_matrix_loader #(.N(8), .WIDTH(8), .SORT_LATENCY(70)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  assign if_a.in_data  = d;
  assign if_a.in_last  = l;
  assign if_a.in_valid = v & ~sel;
  assign if_b.in_data  = d;
  assign if_b.in_last  = l;
  assign if_b.in_valid = v & sel;

  wire cur_ready = sel ? if_b.in_ready : if_a.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (if_a.sort_done) done_a <= done_a + 1;
    if (if_b.sort_done) done_b <= done_b + 1;
    if (if_a.frame_err) ferr_a <= ferr_a + 1;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int base, input int step);
    logic [511:0] m;
    m = '0;
    for (int k = 0; k < 64; k++) m[k*8 +: 8] = 8'(base + step * k);
    return m;
  endfunction

  task automatic step(input int n);
    v = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the element until it is accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [7:0] data, input logic last);
    logic ok;
    int guard;
    guard = 0;
    ok = 1'b0;
    d = data;
    l = last;
    v = 1'b1;
    while (!ok && guard < 300) begin
      ok = cur_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) check("send_timeout", 512'(ok), 512'(1));
  endtask

  task automatic send_matrix(input int base, input int step_v);
    for (int k = 0; k < 64; k++) send(8'(base + step_v * k), (k == 63));
  endtask

  initial begin
    logic [511:0] ones;
    int base_done, base_ferr, acc, guard, w;
    logic ok;
    ones = '1;
    n_assert = 0; n_fail = 0;
    done_a = 0; done_b = 0; ferr_a = 0;
    reset = 1'b1; v = 1'b0; l = 1'b0; d = 8'h00; sel = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_matrix_out", if_a.matrix_out, 512'(0));
    check("rst_matrix_valid", 512'(if_a.matrix_valid), 512'(0));
    check("rst_sort_done", 512'(if_a.sort_done), 512'(0));
    check("rst_busy", 512'(if_a.busy), 512'(0));
    check("rst_frame_err", 512'(if_a.frame_err), 512'(0));
    check("rst_in_ready", 512'(if_a.in_ready), 512'(1));
    reset = 1'b0;
    step(1);

    // Stream 63..0, publish on the last element
    for (int k = 0; k < 63; k++) send(8'(63 - k), 1'b0);
    check("pre_publish_valid", 512'(if_a.matrix_valid), 512'(0));
    send(8'd0, 1'b1);
    v = 1'b0;
    check("m1_elem0", 512'(if_a.matrix_out[7:0]), 512'(63));
    check("m1_elem63", 512'(if_a.matrix_out[511:504]), 512'(0));
    check("m1_full", if_a.matrix_out, mk(63, -1));
    check("m1_valid", 512'(if_a.matrix_valid), 512'(1));
    check("m1_busy_c0", 512'(if_a.busy), 512'(1));
    check("m1_done_c0", 512'(if_a.sort_done), 512'(0));
    step(1);
    check("m1_busy_c1", 512'(if_a.busy), 512'(1));
    check("m1_done_c1", 512'(if_a.sort_done), 512'(0));
    step(1);
    check("m1_busy_c2", 512'(if_a.busy), 512'(0));
    check("m1_done_c2", 512'(if_a.sort_done), 512'(1));
    step(1);
    check("m1_done_c3", 512'(if_a.sort_done), 512'(0));
    check("m1_done_count", 512'(done_a), 512'(1));
    check("m1_no_ferr", 512'(ferr_a), 512'(0));

    // Early in_last on element index 10
    for (int k = 0; k < 10; k++) send(8'(8'hA0 + k), 1'b0);
    send(8'hEE, 1'b1);
    v = 1'b0;
    check("early_ferr", 512'(if_a.frame_err), 512'(1));
    check("early_hold", if_a.matrix_out, mk(63, -1));
    step(1);
    check("early_ferr_pulse", 512'(if_a.frame_err), 512'(0));
    send_matrix(1, 1);
    v = 1'b0;
    check("early_recover", if_a.matrix_out, mk(1, 1));
    step(3);

    // Missing in_last on element 63
    for (int k = 0; k < 64; k++) send(8'h55, 1'b0);
    v = 1'b0;
    check("miss_ferr", 512'(if_a.frame_err), 512'(1));
    check("miss_hold", if_a.matrix_out, mk(1, 1));
    check("miss_ferr_count", 512'(ferr_a), 512'(1));
    step(1);
    send_matrix(0, 5);
    v = 1'b0;
    check("miss_recover", if_a.matrix_out, mk(0, 5));

    // Reset mid-latency: no done pulse for the in-flight matrix
    base_done = done_a;
    reset = 1'b1;
    #1;
    check("rstlat_matrix_out", if_a.matrix_out, 512'(0));
    check("rstlat_busy", 512'(if_a.busy), 512'(0));
    check("rstlat_valid", 512'(if_a.matrix_valid), 512'(0));
    check("rstlat_ready", 512'(if_a.in_ready), 512'(1));
    step(3);
    reset = 1'b0;
    step(4);
    check("rstlat_no_done", 512'(done_a), 512'(base_done));

    // Reset mid-fill at element 30
    for (int k = 0; k < 30; k++) send(8'hC3, 1'b0);
    v = 1'b0;
    reset = 1'b1;
    #1;
    check("rstfill_matrix_out", if_a.matrix_out, 512'(0));
    check("rstfill_frame_err", 512'(if_a.frame_err), 512'(0));
    step(2);
    reset = 1'b0;
    step(1);
    send_matrix(8'h5A, 3);
    v = 1'b0;
    check("rstfill_publish", if_a.matrix_out, mk(8'h5A, 3));
    check("rstfill_valid", 512'(if_a.matrix_valid), 512'(1));
    step(4);

    // Random in_valid gaps with all-ones data; gap contents must be ignored
    base_ferr = ferr_a;
    acc = 0;
    guard = 0;
    while (acc < 64 && guard < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        v = 1'b1; d = 8'hFF; l = (acc == 63);
      end else begin
        v = 1'b0; d = 8'($urandom); l = 1'($urandom);
      end
      ok = v & cur_ready;
      @(posedge clk);
      #1;
      if (ok) acc++;
      guard++;
    end
    v = 1'b0;
    check("rand_accepted", 512'(acc), 512'(64));
    check("rand_all_ones", if_a.matrix_out, ones);
    check("rand_no_ferr", 512'(ferr_a), 512'(base_ferr));
    step(4);

    // Back-to-back on the SORT_LATENCY=70 instance
    sel = 1'b1;
    base_done = done_b;
    for (int k = 0; k < 64; k++) send(8'(k), (k == 63));
    check("b2b_first_publish", if_b.matrix_out, mk(0, 1));
    for (int k = 0; k < 64; k++) send(8'(100 + k), (k == 63));
    v = 1'b0;
    check("b2b_pending_ready", 512'(if_b.in_ready), 512'(0));
    check("b2b_pending_hold", if_b.matrix_out, mk(0, 1));
    check("b2b_pending_busy", 512'(if_b.busy), 512'(1));
    w = 0;
    while (!if_b.in_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("b2b_wait_cycles", 512'(w), 512'(6));
    check("b2b_second_publish", if_b.matrix_out, mk(100, 1));
    check("b2b_done_first", 512'(if_b.sort_done), 512'(1));
    check("b2b_busy_reload", 512'(if_b.busy), 512'(1));
    step(75);
    check("b2b_done_count", 512'(done_b - base_done), 512'(2));
    check("b2b_idle", 512'(if_b.busy), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_matrix_loader.md
Name: sort_matrix_loader

Overview:
- Upstream stage of the mesh sorter. Takes a serial valid/ready stream of WIDTH-bit elements and assembles it row-major into an N*N matrix in a fill buffer.
- Publishes each complete matrix as one atomic update on the flat bus that feeds the sorter, then counts the sorter's fixed latency and pulses sort_done when the sorted result is valid.
- Accepts the next matrix while the current one is in the sorter.

Parameters:
N, 8, matrix dimension (N >= 2, power of two)
WIDTH, 8, element width in bits
SORT_LATENCY, 2, clk edges from publish edge until downstream sorted output is valid (>= 1)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
in_data  input  WIDTH  stream element
in_valid  input  1  in_data/in_last valid
in_last  input  1  marks final element of a matrix
in_ready  output  1  loader accepts element this cycle
matrix_out  output  N*N*WIDTH  published matrix; element k at [k*WIDTH +: WIDTH], row k/N, col k%N
matrix_valid  output  1  high from first publish onward
sort_done  output  1  one-cycle pulse, SORT_LATENCY cycles after a publish
busy  output  1  latency counter non-zero
frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset values (asynchronous): matrix_out=0, matrix_valid=0, sort_done=0, busy=0, frame_err=0, in_ready=1. Fill buffer, element count and latency counter are 0. State is FILL.
- Transfer: occurs when in_valid && in_ready at a rising edge. Element is written to fill buffer slot idx, where idx = element count (clog2(N*N) bits). idx then increments.
- FILL state: in_ready=1.
  - Transfer with idx < N*N-1 and in_last=0: store, idx++.
  - Transfer with idx == N*N-1 and in_last=1: matrix complete. idx returns to 0.
    - If busy=0, or latency counter == 1 on this same edge: publish on this edge.
    - Otherwise go to PENDING.
  - Framing error: in_last=1 with idx < N*N-1, or in_last=0 with idx == N*N-1. Effects:
    - frame_err pulses next cycle.
    - Partial matrix is discarded and idx returns to 0. The erroring element is not stored.
    - matrix_out is unchanged.
- PENDING state: in_ready=0. Move to FILL and publish on the edge where the latency counter goes 1 -> 0.
- Publish (single edge):
  - matrix_out <= fill buffer, with the just-received element merged if completing on this edge.
  - matrix_valid <= 1.
  - Latency counter <= SORT_LATENCY.
  - matrix_out changes only on publish edges and holds otherwise, because the sorter samples it every cycle.
- Latency counter:
  - Decrements while non-zero. busy = (counter != 0).
  - sort_done is registered high for exactly one cycle, on the cycle after the counter reaches 0.
  - Simultaneous expiry and publish: the counter reloads with SORT_LATENCY and sort_done still pulses for the expiring matrix. No done pulse is lost.
- Throughput: with in_valid held high, one matrix per max(N*N, SORT_LATENCY+...) cycles. The loader never back-pressures while filling. It stalls only in PENDING.
- Latency: the last element accepted at edge E gives matrix_out updated at E (when not busy) and sort_done high during the cycle after edge E+SORT_LATENCY.
- Reset mid-fill or mid-latency clears everything. No sort_done is issued for the in-flight matrix.
- in_data and in_last are ignored when no transfer occurs.

Test Plan:
- Reset, then stream 64 elements with values 63..0, in_last on the 64th, in_valid held high. Expect:
  - matrix_out[7:0]=63, matrix_out[511:504]=0, matrix_valid=1.
  - busy high for 2 cycles, then one sort_done pulse.
  - The downstream sorter output is ascending 0..63.
- Back-to-back: two matrices streamed with no gap, SORT_LATENCY=70. Expect:
  - in_ready drops after the 128th element (PENDING).
  - in_ready rises on the edge the first counter expires, and the second matrix publishes on that same edge.
  - Exactly 2 sort_done pulses.
- Early in_last on element index 10. Expect frame_err pulse, matrix_out unchanged. The next 64 valid elements publish normally with first element at slot 0.
- Missing in_last on element 63. Expect frame_err, no publish, idx=0.
- Assert reset at element 30, deassert, then send a full matrix. Expect all outputs 0 during reset and a clean publish at element 64.
- in_valid toggled randomly with all values 0xFF. Expect matrix_out all ones after 64 accepted transfers. Gaps do not advance idx.
